// File: rtl/sync_fifo_cnt.sv
// sync_fifo_cnt: single-clock FIFO with an occupancy counter, registered
// full/empty/almost flags, sticky overflow/underflow flags and a flush.
// Read data is registered and appears one cycle after an accepted read.
module sync_fifo_cnt #(
    parameter int FIFO_PTR      = 4,
    parameter int FIFO_WIDTH    = 32,
    parameter int AFULL_THRESH  = (2 ** FIFO_PTR) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  write_en,
    input  logic [FIFO_WIDTH-1:0] write_data,
    input  logic                  read_en,
    input  logic                  flush,
    input  logic                  clear_err,
    output logic [FIFO_WIDTH-1:0] read_data,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_afull,
    output logic                  fifo_aempty,
    output logic [FIFO_PTR:0]     fifo_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** FIFO_PTR;

    // Occupancy levels expressed in the counter's own width.
    localparam logic [FIFO_PTR:0] DEPTH_CNT  = {1'b1, {FIFO_PTR{1'b0}}};
    localparam logic [FIFO_PTR:0] AFULL_CNT  = (FIFO_PTR + 1)'(AFULL_THRESH);
    localparam logic [FIFO_PTR:0] AEMPTY_CNT = (FIFO_PTR + 1)'(AEMPTY_THRESH);

    logic [FIFO_WIDTH-1:0] mem [DEPTH];

    // Pointers are exactly FIFO_PTR bits wide, so they wrap from depth-1
    // to 0 by natural overflow.
    logic [FIFO_PTR-1:0] wr_ptr;
    logic [FIFO_PTR-1:0] rd_ptr;

    logic                wr_accept;
    logic                rd_accept;
    logic [FIFO_PTR:0]   count_next;
    logic                overflow_set;
    logic                underflow_set;
    logic                overflow_next;
    logic                underflow_next;

    // Accept decisions use the registered flags, so a full FIFO still takes
    // a read (and rejects the write) and an empty FIFO still takes a write.
    always_comb begin
        wr_accept     = write_en && !fifo_full && !flush;
        rd_accept     = read_en && !fifo_empty && !flush;
        overflow_set  = write_en && fifo_full && !flush;
        underflow_set = read_en && fifo_empty && !flush;
    end

    // Next occupancy: flush clears, otherwise +1 / -1 / unchanged.
    always_comb begin
        // NOTE: every combinational output gets a default first so no
        // path through the block can leave it unassigned and infer a latch.
        count_next = fifo_count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({wr_accept, rd_accept})
                2'b10:   count_next = fifo_count + 1'b1;
                2'b01:   count_next = fifo_count - 1'b1;
                default: count_next = fifo_count;
            endcase
        end
    end

    // Sticky error flags: a set condition beats clear_err in the same cycle.
    always_comb begin
        overflow_next  = overflow;
        underflow_next = underflow;
        if (overflow_set) begin
            overflow_next = 1'b1;
        end else if (clear_err) begin
            overflow_next = 1'b0;
        end
        if (underflow_set) begin
            underflow_next = 1'b1;
        end else if (clear_err) begin
            underflow_next = 1'b0;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the data array is deliberately left out of reset; the count
        // and pointers define which entries are valid, and leaving the
        // array unreset lets it map onto plain RAM.
        if (wr_accept) begin
            mem[wr_ptr] <= write_data;
        end
    end

    // Control state: pointers, count, registered flags and read data.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rstb) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            read_data   <= '0;
            fifo_full   <= 1'b0;
            fifo_empty  <= 1'b1;
            fifo_afull  <= 1'b0;
            fifo_aempty <= 1'b1;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_accept) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_accept) begin
                    rd_ptr    <= rd_ptr + 1'b1;
                    read_data <= mem[rd_ptr];
                end
            end
            fifo_count  <= count_next;
            fifo_full   <= (count_next == DEPTH_CNT);
            fifo_empty  <= (count_next == '0);
            fifo_afull  <= (count_next >= AFULL_CNT);
            fifo_aempty <= (count_next <= AEMPTY_CNT);
            overflow    <= overflow_next;
            underflow   <= underflow_next;
        end
    end

endmodule

// File: tb/tb_sync_fifo_cnt.sv
// tb_sync_fifo_cnt: directed test of sync_fifo_cnt with FIFO_PTR=2,
// FIFO_WIDTH=8, AFULL_THRESH=3, AEMPTY_THRESH=1. Inputs change 1 ns after
// a rising edge; outputs are sampled at the same point after the next edge.
module tb_sync_fifo_cnt;

    logic       clk = 1'b0;
    logic       rstb;
    logic       write_en;
    logic [7:0] write_data;
    logic       read_en;
    logic       flush;
    logic       clear_err;
    logic [7:0] read_data;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_afull;
    logic       fifo_aempty;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_fail   = 0;

    sync_fifo_cnt #(
        .FIFO_PTR     (2),
        .FIFO_WIDTH   (8),
        .AFULL_THRESH (3),
        .AEMPTY_THRESH(1)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .write_en   (write_en),
        .write_data (write_data),
        .read_en    (read_en),
        .flush      (flush),
        .clear_err  (clear_err),
        .read_data  (read_data),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_afull (fifo_afull),
        .fifo_aempty(fifo_aempty),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input int cnt, input logic full,
                               input logic empty, input logic afull, input logic aempty);
        check({tag, " count"},  32'(fifo_count),  32'(cnt));
        check({tag, " full"},   32'(fifo_full),   32'(full));
        check({tag, " empty"},  32'(fifo_empty),  32'(empty));
        check({tag, " afull"},  32'(fifo_afull),  32'(afull));
        check({tag, " aempty"}, 32'(fifo_aempty), 32'(aempty));
    endtask

    task automatic check_reset(input string tag);
        check({tag, " read_data"}, 32'(read_data), 32'h0);
        check_flags(tag, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        check({tag, " overflow"},  32'(overflow),  32'h0);
        check({tag, " underflow"}, 32'(underflow), 32'h0);
    endtask

    // Expected flags after each of four writes into an empty FIFO.
    logic [7:0] wr_vals   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic       exp_full  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_afull [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       exp_aempty[4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        rstb       = 1'b0;
        write_en   = 1'b0;
        write_data = 8'h00;
        read_en    = 1'b0;
        flush      = 1'b0;
        clear_err  = 1'b0;
        tick();
        tick();
        check_reset("reset");
        rstb = 1'b1;

        // Fill to full, watching the level flags move.
        for (int i = 0; i < 4; i++) begin
            write_en   = 1'b1;
            write_data = wr_vals[i];
            tick();
            check_flags($sformatf("fill%0d", i + 1), i + 1, exp_full[i], 1'b0,
                        exp_afull[i], exp_aempty[i]);
        end

        // Write while full: discarded, overflow sticks, then clear_err.
        write_data = 8'h55;
        tick();
        check("ovf count", 32'(fifo_count), 32'd4);
        check("ovf set", 32'(overflow), 32'h1);
        write_en  = 1'b0;
        clear_err = 1'b1;
        tick();
        check("ovf cleared", 32'(overflow), 32'h0);
        clear_err = 1'b0;

        // Drain in order; 0x55 must never appear.
        read_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("drain%0d data", i + 1), 32'(read_data), 32'(wr_vals[i]));
            check($sformatf("drain%0d count", i + 1), 32'(fifo_count), 32'(3 - i));
        end
        check("drain empty", 32'(fifo_empty), 32'h1);
        read_en = 1'b0;
        tick();
        check("hold data", 32'(read_data), 32'h44);
        check("no underflow", 32'(underflow), 32'h0);

        // Preload two, then six simultaneous write/read cycles across the wrap.
        write_en = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            write_data = 8'(i);
            tick();
        end
        read_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            write_data = 8'(i + 3);
            tick();
            check($sformatf("rw%0d data", i), 32'(read_data), 32'(i + 1));
            check($sformatf("rw%0d count", i), 32'(fifo_count), 32'd2);
        end
        write_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("tail%0d data", i), 32'(read_data), 32'(i + 7));
        end
        read_en = 1'b0;
        check("tail empty", 32'(fifo_empty), 32'h1);

        // Read and write while empty: write taken, read rejected.
        write_en   = 1'b1;
        read_en    = 1'b1;
        write_data = 8'hAA;
        tick();
        check("unf set", 32'(underflow), 32'h1);
        check("unf count", 32'(fifo_count), 32'd1);
        check("unf hold data", 32'(read_data), 32'h08);
        write_en = 1'b0;
        tick();
        check("unf readback", 32'(read_data), 32'hAA);
        check("unf count0", 32'(fifo_count), 32'd0);
        read_en   = 1'b0;
        clear_err = 1'b1;
        tick();
        check("unf cleared", 32'(underflow), 32'h0);

        // clear_err together with a new underflow: set wins.
        read_en = 1'b1;
        tick();
        check("set wins", 32'(underflow), 32'h1);
        read_en   = 1'b0;
        clear_err = 1'b0;

        // Flush at count 3 with a write pending; underflow must survive.
        write_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            write_data = 8'hB1 + 8'(i);
            tick();
        end
        check("pre-flush count", 32'(fifo_count), 32'd3);
        flush      = 1'b1;
        write_data = 8'hCC;
        tick();
        check_flags("flush", 0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("flush unf kept", 32'(underflow), 32'h1);
        check("flush ovf kept", 32'(overflow), 32'h0);
        check("flush hold data", 32'(read_data), 32'hAA);
        flush      = 1'b0;
        write_data = 8'hDD;
        tick();
        write_en = 1'b0;
        read_en  = 1'b1;
        tick();
        check("post-flush data", 32'(read_data), 32'hDD);
        read_en = 1'b0;

        // Reset at count 2 discards everything.
        write_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            write_data = 8'hE1 + 8'(i);
            tick();
        end
        check("pre-reset count", 32'(fifo_count), 32'd2);
        write_en = 1'b0;
        rstb     = 1'b0;
        tick();
        check_reset("mid reset");
        rstb       = 1'b1;
        write_en   = 1'b1;
        write_data = 8'hF1;
        tick();
        write_en = 1'b0;
        read_en  = 1'b1;
        tick();
        check("post-reset data", 32'(read_data), 32'hF1);
        check("post-reset empty", 32'(fifo_empty), 32'h1);
        read_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
